// File: rtl/statseg_defs.sv
// Shared definitions for the status segment write path: word width, field masks
// and the writer FSM state encoding.
package statseg_defs;

   localparam int STAT_WIDTH = 20;

   localparam logic [STAT_WIDTH-1:0] FLAGS_MASK = 20'h0000F;  // Z, N, C, V
   localparam logic [STAT_WIDTH-1:0] MODE_MASK  = 20'h000F0;
   localparam logic [STAT_WIDTH-1:0] SEG_MASK   = 20'hFFF00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MERGE  = 2'd1,
      ST_LOAD   = 2'd2,
      ST_SETTLE = 2'd3
   } wr_state_e;

endpackage

// File: rtl/statseg_wq.sv
// Update queue for the status segment writer: DEPTH entries of WIDTH bits,
// power-of-two depth so the pointers wrap for free; a count tells full from empty.
module statseg_wq #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // storage needs no reset; occupancy decides what is valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/statseg_writer.sv
// Write-side controller for the status segment: queues masked field updates and
// applies each one as a read-modify-write against the live register contents.
//
// state  | meaning
// IDLE   | nothing in flight; leave when the queue holds an update
// MERGE  | pop head entry, register merged word from stat_cur
// LOAD   | loadsig high for one cycle with load_data stable
// SETTLE | let statseg capture so the next merge sees the new word
module statseg_writer
   import statseg_defs::*;
#(
   parameter int WIDTH = STAT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [WIDTH-1:0] upd_mask,
   input  logic [WIDTH-1:0] upd_data,
   input  logic [WIDTH-1:0] stat_cur,
   output logic             loadsig,
   output logic [WIDTH-1:0] load_data,
   output logic             busy,
   output logic [7:0]       drop_count
);

   localparam int CW = $clog2(DEPTH + 1);

   wr_state_e          state;
   wr_state_e          state_nx;
   logic               wq_full;
   logic               wq_empty;
   logic               wq_pop;
   logic [CW-1:0]      wq_count;
   logic [2*WIDTH-1:0] wq_head;
   logic [WIDTH-1:0]   head_mask;
   logic [WIDTH-1:0]   head_data;

   statseg_wq #(
      .WIDTH (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_wq (
      .clk       (clk),
      .reset     (reset),
      .push      (upd_valid),
      .push_data ({upd_mask, upd_data}),
      .pop       (wq_pop),
      .pop_data  (wq_head),
      .full      (wq_full),
      .empty     (wq_empty),
      .count     (wq_count)
   );

   assign {head_mask, head_data} = wq_head;

   // decoded straight from state so an async reset kills the strobe at once
   assign upd_ready = !wq_full;
   assign wq_pop    = (state == ST_MERGE);
   assign loadsig   = (state == ST_LOAD);
   assign busy      = (wq_count != '0) || (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (!wq_empty) state_nx = ST_MERGE;
         ST_MERGE:  state_nx = ST_LOAD;
         ST_LOAD:   state_nx = ST_SETTLE;
         ST_SETTLE: state_nx = wq_empty ? ST_IDLE : ST_MERGE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_data <= '0;
      end else if (state == ST_MERGE) begin
         load_data <= (stat_cur & ~head_mask) | (head_data & head_mask);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count <= '0;
      end else if (upd_valid && wq_full && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_statseg_writer.sv
// Bench for statseg_writer with a behavioural statseg register on the loop;
// expected load words are queued by the stimulus and checked by a load monitor.
module tb_statseg_writer;
   import statseg_defs::*;

   localparam int W = STAT_WIDTH;

   logic         clk;
   logic         reset;
   logic         upd_valid;
   logic         upd_ready;
   logic [W-1:0] upd_mask;
   logic [W-1:0] upd_data;
   logic [W-1:0] stat_cur;
   logic         loadsig;
   logic [W-1:0] load_data;
   logic         busy;
   logic [7:0]   drop_count;

   logic         pre_en;
   logic [W-1:0] pre_val;
   int           n_vec;
   int           n_fail;
   int           cyc;
   logic [W-1:0] exp_q[$];
   int           load_cyc[$];
   logic         prev_load;
   logic [W-1:0] mon_exp;

   logic [W-1:0] ov_data [6] = '{20'h01111, 20'h02222, 20'h03333,
                                 20'h04444, 20'h05555, 20'h06666};
   logic         ov_acc  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   statseg_writer dut (
      .clk        (clk),
      .reset      (reset),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_mask   (upd_mask),
      .upd_data   (upd_data),
      .stat_cur   (stat_cur),
      .loadsig    (loadsig),
      .load_data  (load_data),
      .busy       (busy),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // statseg stand-in, with a preload port so tests can start from any word
   always @(posedge clk or negedge reset) begin
      if (!reset)       stat_cur <= '0;
      else if (pre_en)  stat_cur <= pre_val;
      else if (loadsig) stat_cur <= load_data;
   end

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && loadsig) begin
         chk("load_pulse_single_cycle", 32'(prev_load), 32'd0);
         if (exp_q.size() == 0) begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL unexpected_load: got %0h, expected no load", load_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("load_data", 32'(load_data), 32'(mon_exp));
         end
         load_cyc.push_back(cyc);
      end
      prev_load = reset && loadsig;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [W-1:0] v);
      pre_val = v;
      pre_en  = 1'b1;
      tick();
      pre_en  = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] m, input logic [W-1:0] d,
                       input logic [W-1:0] e, input bit push_exp);
      int n = 0;
      upd_mask = m;
      upd_data = d;
      while (!upd_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready_timeout", 32'(upd_ready), 32'd1);
      upd_valid = 1'b1;
      if (push_exp) exp_q.push_back(e);
      tick();
      upd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic single_test();
      preload(20'hAD1);
      send(FLAGS_MASK, 20'h00005, 20'hAD5, 1'b1);
      chk("single_busy_after_accept", 32'(busy), 32'd1);
      chk("single_no_load_t0", 32'(loadsig), 32'd0);
      tick();
      chk("single_no_load_merge", 32'(loadsig), 32'd0);
      tick();
      chk("single_load_strobe", 32'(loadsig), 32'd1);
      chk("single_load_data", 32'(load_data), 32'hAD5);
      tick();
      chk("single_settle_no_load", 32'(loadsig), 32'd0);
      chk("single_settle_busy", 32'(busy), 32'd1);
      tick();
      chk("single_idle_busy", 32'(busy), 32'd0);
      chk("single_stat_word", 32'(stat_cur), 32'hAD5);
   endtask

   initial begin
      int n;
      n_vec     = 0;
      n_fail    = 0;
      cyc       = 0;
      prev_load = 1'b0;
      pre_en    = 1'b0;
      pre_val   = '0;
      reset     = 1'b0;
      upd_valid = 1'b1;
      upd_mask  = 20'hFFFFF;
      upd_data  = 20'h12345;

      // reset held with a pending update
      repeat (2) @(posedge clk);
      #1;
      chk("rst_loadsig", 32'(loadsig), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      chk("rst_load_data", 32'(load_data), 32'd0);
      upd_valid = 1'b0;
      #1 reset = 1'b1;
      tick();
      chk("rst_no_accept_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(upd_ready), 32'd1);

      single_test();

      // back-to-back read-modify-write through the live register
      preload(20'h00000);
      load_cyc.delete();
      send(MODE_MASK, 20'h00030, 20'h00030, 1'b1);
      send(SEG_MASK,  20'h12300, 20'h12330, 1'b1);
      wait_idle();
      chk("rmw_loads_seen", 32'(load_cyc.size()), 32'd2);
      if (load_cyc.size() == 2)
         chk("rmw_pulse_spacing", 32'(load_cyc[1] - load_cyc[0]), 32'd3);
      chk("rmw_final_word", 32'(stat_cur), 32'h12330);

      // overflow: valid held six cycles from an empty queue
      exp_q.push_back(20'h01111);
      exp_q.push_back(20'h02222);
      exp_q.push_back(20'h04444);
      for (int i = 0; i < 6; i++) begin
         upd_mask  = 20'hFFFFF;
         upd_data  = ov_data[i];
         upd_valid = 1'b1;
         chk("ovf_ready", 32'(upd_ready), 32'(ov_acc[i]));
         tick();
      end
      upd_valid = 1'b0;
      wait_idle();
      chk("ovf_drop_count", 32'(drop_count), 32'd3);
      chk("ovf_all_loaded", 32'(exp_q.size()), 32'd0);
      chk("ovf_final_word", 32'(stat_cur), 32'h04444);

      // mask extremes
      preload(20'hABCDE);
      send(20'h00000, 20'hFFFFF, 20'hABCDE, 1'b1);
      wait_idle();
      preload(20'h3C3C3);
      send(20'hFFFFF, 20'h5A5A5, 20'h5A5A5, 1'b1);
      wait_idle();
      chk("fullmask_word", 32'(stat_cur), 32'h5A5A5);

      // asynchronous reset while the load strobe is high
      preload(20'h00000);
      send(20'hFFFFF, 20'h11111, 20'h0, 1'b0);
      send(20'hFFFFF, 20'h22222, 20'h0, 1'b0);
      n = 0;
      while (!loadsig && n < 20) begin
         tick();
         n++;
      end
      chk("arst_reached_load", 32'(loadsig), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("arst_loadsig_drop", 32'(loadsig), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(upd_ready), 32'd1);
      chk("arst_drop_count", 32'(drop_count), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      tick();
      chk("arst_queue_flushed", 32'(busy), 32'd0);
      tick();
      chk("arst_no_stray_load", 32'(busy), 32'd0);
      single_test();
      chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/statseg_writer.md
Name: statseg_writer

Overview:
- Write-side controller for the 20-bit status segment register. Execution units post masked field updates; this block merges each update with the register's current contents and drives the register's load strobe and load data.
- Sits between the ALU/control unit (update producers) and statseg (storage). It reads the current status word back from the register's data_out.
- Serializes overlapping updates so no read-modify-write is lost.

Parameters:
- WIDTH, 20, status word width; must equal the statseg width.
- DEPTH, 2, update queue entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- upd_valid  in  1  producer presents an update.
- upd_ready  out  1  queue can accept an update.
- upd_mask  in  WIDTH  1 = field bit is replaced.
- upd_data  in  WIDTH  new values for the masked bits.
- stat_cur  in  WIDTH  current status word, wired from statseg data_out.
- loadsig  out  1  load strobe to statseg; one cycle per update.
- load_data  out  WIDTH  merged word, wired to statseg data_in.
- busy  out  1  high while the queue is non-empty or the FSM is not IDLE.
- drop_count  out  8  count of updates presented while upd_ready was low; saturates at 255.

Behaviour:
- Reset (reset low, any time, asynchronous): queue empty, FSM to IDLE, loadsig=0, load_data=0, busy=0, drop_count=0, upd_ready=1 once reset deasserts.
- Reset mid-operation: any in-flight load is abandoned, and loadsig drops immediately.
- Enqueue:
  - An update is accepted when upd_valid and upd_ready are both high at a clock edge.
  - upd_ready = queue not full. This is a combinational function of registered state only, with no dependence on upd_valid.
- Drops: upd_valid high while upd_ready is low increments drop_count by 1 per cycle; the update is not stored.
- Simultaneous enqueue and dequeue when full: not allowed. upd_ready is based on the current occupancy only, not on a same-cycle pop.
- FSM states:
  - IDLE: if the queue is non-empty, go to MERGE.
  - MERGE: pop the head entry. Register load_data = (stat_cur & ~mask) | (data & mask). Go to LOAD.
  - LOAD: loadsig=1 for exactly this cycle, with load_data held stable. Go to SETTLE.
  - SETTLE: loadsig=0; wait one cycle so stat_cur reflects the new word. Then go to MERGE if the queue is non-empty, else IDLE.
- Latency for an update accepted at edge T with the FSM in IDLE:
  - MERGE at T+1.
  - loadsig high in the cycle after edge T+2.
  - statseg updates at edge T+3.
  - A second queued update merges at T+4 and sees the first update's result.
- Sustained throughput: one update per 3 cycles.
- Zero mask: still performs a load, with load_data equal to stat_cur. There is no special-casing.
- Full mask: load_data = upd_data, independent of stat_cur.
- Queue pointers wrap modulo DEPTH. A separate occupancy counter (0..DEPTH) distinguishes full from empty.
- load_data holds its last value between loads; it is only meaningful while loadsig is high.
- busy is registered-state only and goes low in the first IDLE cycle with an empty queue.

Decomposition:
- Shared package/header `statseg_defs`:
  - STAT_WIDTH = 20.
  - Field masks: FLAGS [3:0] (Z, N, C, V), MODE [7:4], SEG [19:8].
  - FSM state encodings: IDLE=0, MERGE=1, LOAD=2, SETTLE=3.
- One sub-module, `statseg_wq`: a parameterized DEPTH x (2*WIDTH) queue with push/pop/full/empty/count. The FSM and merge logic stay in statseg_writer.

Test Plan:
- Reset behaviour: hold reset low for 2 cycles with upd_valid=1 -> loadsig=0, busy=0, drop_count=0, and no update is accepted.
- Single masked update: stat_cur=20'hAD1, mask=20'h0000F, data=20'h00005 -> one loadsig pulse 2 cycles after acceptance with load_data=20'hAD5; busy then low.
- Read-modify-write ordering: with statseg attached at reset value 0, send back-to-back update A (mask 20'h000F0, data 20'h00030) then update B (mask 20'hFFF00, data 20'h12300) -> loads 20'h00030 then 20'h12330, with loadsig pulses 3 cycles apart.
- Overflow: hold upd_valid high for 6 consecutive cycles starting from an empty queue -> 2 accepted immediately, further accepts only as entries drain, drop_count equals the number of cycles with upd_valid high and upd_ready low, and all accepted updates are loaded in order.
- Asynchronous reset during LOAD: assert reset low mid-cycle while loadsig=1 -> loadsig=0 without waiting for a clock edge, the queue is flushed, and a subsequent update behaves exactly as in the single-update test.
- Mask extremes: mask=0 -> load_data=stat_cur; mask=20'hFFFFF, data=20'h5A5A5 -> load_data=20'h5A5A5 regardless of stat_cur.
